// File: rtl/fft_frame_ctrl_if.sv
// Handshake bundle shared by fft_frame_ctrl, the ADC capture stage, the FFT core
// and the result FIFO. master = frame controller side, slave = its environment.
interface fft_frame_ctrl_if #(
  parameter int ADC_W = 14
);
  logic             ad_valid;
  logic [ADC_W-1:0] ad_data;
  logic             ad_ovr;
  logic [15:0]      cfg_tdata;
  logic             cfg_tvalid;
  logic             cfg_tready;
  logic [31:0]      s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic             m_tvalid;
  logic             m_tlast;
  logic             out_wr_en;

  modport master (
    input  ad_valid, ad_data, ad_ovr, cfg_tready, s_tready, m_tvalid, m_tlast,
    output cfg_tdata, cfg_tvalid, s_tdata, s_tvalid, s_tlast, out_wr_en
  );

  modport slave (
    output ad_valid, ad_data, ad_ovr, cfg_tready, s_tready, m_tvalid, m_tlast,
    input  cfg_tdata, cfg_tvalid, s_tdata, s_tvalid, s_tlast, out_wr_en
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer between ADC capture and a streaming FFT core: one config word, then N samples.
// Optional macro FFT_OVR_DISCARD_EN: frames with an overrange are discarded and recaptured.
//
// state  | meaning
// IDLE   | waiting for start
// CONFIG | config word offered to the FFT core
// LOAD   | streaming N ADC samples through the holding register
// DRAIN  | all samples sent, waiting for the last output beat
// DONE   | one-cycle frame completion
module fft_frame_ctrl #(
  parameter int          NFFT_LOG2 = 10,
  parameter int          ADC_W     = 14,
  parameter logic [15:0] CFG_WORD  = 16'h0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  fft_frame_ctrl_if.master bus,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic [15:0]      frame_cnt_o,
  output logic             ovr_flag_o,
  output logic             frame_err_o
);
  localparam int CW = NFFT_LOG2 + 1;
  localparam logic [NFFT_LOG2-1:0] IN_LAST  = '1;
  localparam logic [NFFT_LOG2-1:0] IN_ONE   = 1;
  localparam logic [CW-1:0]        OUT_LAST = {1'b0, IN_LAST};
  localparam logic [CW-1:0]        OUT_FULL = {1'b1, {NFFT_LOG2{1'b0}}};
  localparam logic [CW-1:0]        OUT_ONE  = 1;

  typedef enum logic [2:0] {IDLE, CONFIG, LOAD, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    cfg_tvalid_q, cfg_tvalid_d;
  logic                    hold_full_q, hold_full_d;
  logic signed [ADC_W-1:0] hold_data_q, hold_data_d;
  logic [NFFT_LOG2-1:0]    in_cnt_q, in_cnt_d;
  logic [CW-1:0]           out_cnt_q, out_cnt_d;
  logic                    ovr_flag_q, ovr_flag_d;
  logic                    frame_err_q, frame_err_d;
  logic                    frame_done_q, frame_done_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  logic out_active;
  logic s_xfer;
  logic last_xfer;
  logic beat;
  logic beat_last;
  logic wr_gate;
  logic load_entry;
  logic discard;

`ifdef FFT_OVR_DISCARD_EN
  assign discard = ovr_flag_q;
`else
  assign discard = 1'b0;
`endif

  assign out_active = (state_q == LOAD) || (state_q == DRAIN);
  assign s_xfer     = hold_full_q && bus.s_tready;
  assign last_xfer  = s_xfer && (in_cnt_q == IN_LAST);
  assign beat       = out_active && bus.m_tvalid;
  assign beat_last  = beat && (out_cnt_q == OUT_LAST);
  assign wr_gate    = out_active && (out_cnt_q <= OUT_LAST) && !discard;

  always_comb begin
    state_d      = state_q;
    cfg_tvalid_d = cfg_tvalid_q;
    hold_full_d  = hold_full_q;
    hold_data_d  = hold_data_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    ovr_flag_d   = ovr_flag_q;
    frame_err_d  = frame_err_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    load_entry   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = CONFIG;
          cfg_tvalid_d = 1'b1;
        end
      end
      CONFIG: begin
        if (cfg_tvalid_q && bus.cfg_tready) begin
          state_d      = LOAD;
          cfg_tvalid_d = 1'b0;
          load_entry   = 1'b1;
        end
      end
      LOAD: begin
        if (last_xfer) state_d = DRAIN;
      end
      DRAIN: begin
        // OUT_FULL covers a core that already delivered all beats during LOAD
        if (beat_last || (out_cnt_q == OUT_FULL)) begin
          state_d = DONE;
          if (!discard) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
          end
        end
      end
      DONE: begin
        if (start_i || discard) begin
          state_d    = LOAD;
          load_entry = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == LOAD) begin
      if (s_xfer) begin
        hold_full_d = 1'b0;
        in_cnt_d    = in_cnt_q + IN_ONE;
      end
      // a strobe arriving with the final transfer belongs to no frame
      if (bus.ad_valid && !last_xfer) begin
        if (!hold_full_q || s_xfer) begin
          hold_full_d = 1'b1;
          hold_data_d = bus.ad_data;
        end else begin
          ovr_flag_d = 1'b1;
        end
        if (bus.ad_ovr) ovr_flag_d = 1'b1;
      end
    end

    if (beat) begin
      if (out_cnt_q != OUT_FULL) out_cnt_d = out_cnt_q + OUT_ONE;
      if (bus.m_tlast != (out_cnt_q == OUT_LAST)) frame_err_d = 1'b1;
    end

    if (load_entry) begin
      ovr_flag_d  = 1'b0;
      in_cnt_d    = '0;
      out_cnt_d   = '0;
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_tvalid_q <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      ovr_flag_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cfg_tvalid_q <= cfg_tvalid_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      ovr_flag_q   <= ovr_flag_d;
      frame_err_q  <= frame_err_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.cfg_tdata  = CFG_WORD;
  assign bus.cfg_tvalid = cfg_tvalid_q;
  assign bus.s_tdata    = {16'h0000, 16'(hold_data_q)};
  assign bus.s_tvalid   = hold_full_q;
  assign bus.s_tlast    = hold_full_q && (in_cnt_q == IN_LAST);
  assign bus.out_wr_en  = bus.m_tvalid && wr_gate;

  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign ovr_flag_o   = ovr_flag_q;
  assign frame_err_o  = frame_err_q;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with N = 8; samples are scoreboarded at the FFT input.
module tb_fft_frame_ctrl;
  localparam int NL = 3;
  localparam int AW = 14;
`ifdef FFT_OVR_DISCARD_EN
  localparam bit DISC = 1'b1;
`else
  localparam bit DISC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, frame_done, ovr_flag, frame_err;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int n_cfgv = 0;
  int n_cfg_hs = 0;
  int n_wr = 0;
  logic [32:0] sb[$];

  fft_frame_ctrl_if #(.ADC_W(AW)) bus ();

  fft_frame_ctrl #(.NFFT_LOG2(NL), .ADC_W(AW), .CFG_WORD(16'h0001)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .bus          (bus),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .frame_cnt_o  (frame_cnt),
    .ovr_flag_o   (ovr_flag),
    .frame_err_o  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [AW-1:0] v);
    return {16'h0000, {(16-AW){v[AW-1]}}, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (bus.cfg_tvalid) n_cfgv++;
    if (bus.cfg_tvalid && bus.cfg_tready) begin
      n_cfg_hs++;
      chk("cfg_tdata", 32'(bus.cfg_tdata), 32'h0000_0001);
    end
    if (bus.out_wr_en) n_wr++;
    if (bus.s_tvalid && bus.s_tready) begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = 33'h1_DEAD_BEEF;
      chk("s_tdata", bus.s_tdata, e[31:0]);
      chk("s_tlast", 32'(bus.s_tlast), 32'(e[32]));
    end
  end

  // Streams samples first..7 (sample ovr_idx carries ad_ovr), then 8 core output beats.
  task automatic run_frame(input int base, input int first, input int ovr_idx,
                           input int tlast_pos, input logic exp_done, input int exp_wr);
    int w0;
    logic [AW-1:0] v;
    w0 = n_wr;
    for (int i = first; i < 8; i++) begin
      v = AW'(base + i);
      bus.ad_valid = 1'b1;
      bus.ad_data  = v;
      bus.ad_ovr   = (i == ovr_idx);
      sb.push_back({(i == 7), ext(v)});
      tick();
    end
    bus.ad_valid = 1'b0;
    bus.ad_ovr   = 1'b0;
    tick();
    for (int b = 1; b <= 8; b++) begin
      bus.m_tvalid = 1'b1;
      bus.m_tlast  = (b == tlast_pos);
      tick();
    end
    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    chk("wr_beats", 32'(n_wr - w0), 32'(exp_wr));
  endtask

  task automatic begin_frame();
    start = 1'b1;
    bus.cfg_tready = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    int h0;
    int c0;
    bus.ad_valid   = 1'b0;
    bus.ad_data    = '0;
    bus.ad_ovr     = 1'b0;
    bus.cfg_tready = 1'b0;
    bus.s_tready   = 1'b1;
    bus.m_tvalid   = 1'b0;
    bus.m_tlast    = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 32'({busy, frame_done, frame_cnt, ovr_flag, frame_err,
        bus.cfg_tvalid, bus.s_tvalid, bus.s_tlast, bus.out_wr_en}), 32'h0);
    chk("reset_s_tdata", bus.s_tdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // basic frame: values 1..8
    start = 1'b1;
    bus.cfg_tready = 1'b1;
    tick();
    chk("cfg_tvalid_rise", 32'(bus.cfg_tvalid), 32'h1);
    chk("busy_config", 32'(busy), 32'h1);
    start = 1'b0;
    tick();
    chk("cfg_tvalid_fall", 32'(bus.cfg_tvalid), 32'h0);
    run_frame(1, 0, 8, 8, 1'b1, 8);
    chk("cfg_hs_once", 32'(n_cfg_hs), 32'h1);
    chk("frame_cnt_1", 32'(frame_cnt), 32'h1);
    tick();
    chk("idle_busy", 32'(busy), 32'h0);
    chk("done_pulse_width", 32'(frame_done), 32'h0);

    // config stall: cfg_tready low for 5 cycles, ADC strobes must be ignored
    start = 1'b1;
    bus.cfg_tready = 1'b0;
    c0 = n_cfgv;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ad_valid = 1'b1;
      bus.ad_data  = AW'(5);
      tick();
    end
    chk("no_s_tvalid_in_config", 32'(bus.s_tvalid), 32'h0);
    bus.ad_valid = 1'b0;
    bus.cfg_tready = 1'b1;
    tick();
    chk("cfg_tvalid_cycles", 32'(n_cfgv - c0), 32'd6);
    chk("cfg_tvalid_after_hs", 32'(bus.cfg_tvalid), 32'h0);
    run_frame(20, 0, 8, 8, 1'b1, 8);
    chk("frame_cnt_2", 32'(frame_cnt), 32'd2);
    tick();

    // holding register full: -3 held, 7 dropped
    begin_frame();
    bus.s_tready = 1'b0;
    bus.ad_valid = 1'b1;
    bus.ad_data  = AW'(-3);
    sb.push_back({1'b0, ext(AW'(-3))});
    tick();
    bus.ad_data = AW'(7);
    tick();
    bus.ad_valid = 1'b0;
    chk("ovr_on_drop", 32'(ovr_flag), 32'h1);
    chk("held_neg3", bus.s_tdata, 32'h0000_FFFD);
    chk("held_valid", 32'(bus.s_tvalid), 32'h1);
    bus.s_tready = 1'b1;
    run_frame(10, 1, 8, 8, !DISC, DISC ? 0 : 8);
    tick();
`ifdef FFT_OVR_DISCARD_EN
    run_frame(40, 0, 8, 8, 1'b1, 8);
    tick();
`endif
    chk("frame_cnt_3", 32'(frame_cnt), 32'd3);
    chk("ovr_after_frame", 32'(ovr_flag), 32'(!DISC));

    // m_tlast misplaced on beat 6
    chk("err_clear", 32'(frame_err), 32'h0);
    begin_frame();
    chk("ovr_cleared_on_load", 32'(ovr_flag), 32'h0);
    run_frame(50, 0, 8, 6, 1'b1, 8);
    chk("frame_err_set", 32'(frame_err), 32'h1);
    chk("frame_cnt_4", 32'(frame_cnt), 32'd4);
    tick();

    // back-to-back frames with start held high
    h0 = n_cfg_hs;
    start = 1'b1;
    tick();
    tick();
    run_frame(60, 0, 8, 8, 1'b1, 8);
    tick();
    chk("busy_between", 32'(busy), 32'h1);
    run_frame(70, 0, 8, 8, 1'b1, 8);
    tick();
    start = 1'b0;
    run_frame(80, 0, 8, 8, 1'b1, 8);
    tick();
    chk("b2b_cfg_once", 32'(n_cfg_hs - h0), 32'h1);
    chk("frame_cnt_7", 32'(frame_cnt), 32'd7);
    chk("b2b_idle", 32'(busy), 32'h0);
    chk("frame_err_sticky", 32'(frame_err), 32'h1);

    // ad_ovr on sample 4
    begin_frame();
    run_frame(100, 0, 3, 8, !DISC, DISC ? 0 : 8);
    chk("ovr_from_adc", 32'(ovr_flag), 32'h1);
    tick();
`ifdef FFT_OVR_DISCARD_EN
    run_frame(110, 0, 8, 8, 1'b1, 8);
    tick();
`endif
    chk("frame_cnt_8", 32'(frame_cnt), 32'd8);

    // asynchronous reset in the middle of LOAD
    begin_frame();
    for (int i = 0; i < 3; i++) begin
      bus.ad_valid = 1'b1;
      bus.ad_data  = AW'(200 + i);
      sb.push_back({1'b0, ext(AW'(200 + i))});
      tick();
    end
    bus.ad_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({busy, frame_done, frame_cnt, ovr_flag, frame_err,
        bus.cfg_tvalid, bus.s_tvalid, bus.s_tlast, bus.out_wr_en}), 32'h0);
    chk("sb_before_reset", 32'(sb.size()), 32'h1);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    h0 = n_cfg_hs;
    begin_frame();
    run_frame(300, 0, 8, 8, 1'b1, 8);
    chk("cfg_resent", 32'(n_cfg_hs - h0), 32'h1);
    chk("frame_cnt_after_reset", 32'(frame_cnt), 32'h1);
    chk("err_after_reset", 32'(frame_err), 32'h0);
    tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
